// File: rtl/pixel_stream_pkg.sv
// Geometry and widths shared by the pixel generator, packer and unpacker.
// Four RGB888 pixels travel in three 32-bit words, stream byte order R,G,B.
package pixel_stream_pkg;
  localparam int X_SIZE_DEF    = 640;
  localparam int Y_SIZE_DEF    = 480;
  localparam int BYTES_PER_PIX = 3;
  localparam int WORD_BYTES    = 4;
  localparam int BUF_BYTES     = 8;
  localparam int CNT_W         = 4;
  localparam int X_W           = 10;
  localparam int Y_W           = 9;

  // r sits in the low byte so the struct overlays buffer bytes 0..2 directly
  typedef struct packed {
    logic [7:0] b;
    logic [7:0] g;
    logic [7:0] r;
  } rgb_t;
endpackage

// File: rtl/byte_realign_buf.sv
// 8-byte FIFO-ordered realignment buffer: push 4 bytes, pop 3, flush on frame start.
// Pop and push in one cycle shift the residue down first, then append the word behind it.
module byte_realign_buf
  import pixel_stream_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [31:0]      word_i,
  output rgb_t             pix_o,
  output logic [CNT_W-1:0] cnt_o
);
  logic [BUF_BYTES*8-1:0] buf_q, buf_d, base, keep_mask;
  logic [CNT_W-1:0]       cnt_q, cnt_d, base_cnt;
  logic [6:0]             sh;

  always_comb begin
    base     = pop_i ? (buf_q >> (BYTES_PER_PIX * 8)) : buf_q;
    base_cnt = pop_i ? (cnt_q - CNT_W'(BYTES_PER_PIX)) : cnt_q;
    if (flush_i) base_cnt = '0;
    sh        = {base_cnt, 3'b000};
    keep_mask = ~({(BUF_BYTES * 8){1'b1}} << sh);
    buf_d     = base;
    cnt_d     = base_cnt;
    if (push_i) begin
      buf_d = (base & keep_mask) | ({32'b0, word_i} << sh);
      cnt_d = base_cnt + CNT_W'(WORD_BYTES);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      buf_q <= '0;
      cnt_q <= '0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
    end
  end

  assign pix_o = rgb_t'(buf_q[23:0]);
  assign cnt_o = cnt_q;
endmodule

// File: rtl/pixel_unpacker.sv
// AXI4-Stream 32-bit sink that rebuilds RGB888 pixels with x/y and checks tuser/tlast framing.
// Pixel valid one cycle after the word lands; tready depends only on buffer fill, never on pix_ready.
module pixel_unpacker
  import pixel_stream_pkg::*;
#(
  parameter int X_SIZE = X_SIZE_DEF,
  parameter int Y_SIZE = Y_SIZE_DEF
) (
  input  logic           aclk,
  input  logic           areset,
  input  logic [31:0]    in_stream_tdata,
  input  logic [3:0]     in_stream_tkeep,
  input  logic           in_stream_tlast,
  input  logic           in_stream_tuser,
  input  logic           in_stream_tvalid,
  output logic           in_stream_tready,
  output logic [7:0]     pix_r,
  output logic [7:0]     pix_g,
  output logic [7:0]     pix_b,
  output logic [X_W-1:0] pix_x,
  output logic [Y_W-1:0] pix_y,
  output logic           pix_sof,
  output logic           pix_eol,
  output logic           pix_valid,
  input  logic           pix_ready,
  output logic           err_sof,
  output logic           err_eol,
  output logic           err_keep
);
  localparam logic [X_W-1:0]   X_LAST    = X_W'(X_SIZE - 1);
  localparam logic [Y_W-1:0]   Y_LAST    = Y_W'(Y_SIZE - 1);
  localparam logic [CNT_W-1:0] POP_BYTES = CNT_W'(BYTES_PER_PIX);
  localparam logic [CNT_W-1:0] MAX_FILL  = CNT_W'(BUF_BYTES - WORD_BYTES);

  rgb_t             pix;
  logic [CNT_W-1:0] cnt, cnt_pop;
  logic             acc, pop, frame_start, line_done;
  logic [X_W-1:0]   x_q, x_d;
  logic [Y_W-1:0]   y_q, y_d, y_next;
  logic             last_q, last_d;
  logic             err_sof_q, err_sof_d, err_eol_q, err_eol_d, err_keep_q, err_keep_d;

  byte_realign_buf u_buf (
    .clk_i  (aclk),
    .rst_i  (areset),
    .push_i (acc),
    .pop_i  (pop),
    .flush_i(frame_start),
    .word_i (in_stream_tdata),
    .pix_o  (pix),
    .cnt_o  (cnt)
  );

  assign in_stream_tready = !areset && (cnt <= MAX_FILL);
  assign pix_valid        = !areset && (cnt >= POP_BYTES);
  assign acc              = in_stream_tvalid && in_stream_tready;
  assign pop              = pix_valid && pix_ready;
  assign frame_start      = acc && in_stream_tuser;
  assign cnt_pop          = pop ? (cnt - POP_BYTES) : cnt;
  // A line is exhausted when the pop leaves no residue; a word accepted alongside belongs to the next line
  assign line_done        = last_q && (cnt_pop == '0);
  assign y_next           = (y_q == Y_LAST) ? '0 : y_q + 1'b1;

  always_comb begin
    x_d        = x_q;
    y_d        = y_q;
    last_d     = last_q;
    err_sof_d  = err_sof_q;
    err_eol_d  = err_eol_q;
    err_keep_d = err_keep_q;
    if (pop) begin
      if (pix_eol) begin
        x_d = '0;
        y_d = y_next;
        if (!line_done) err_eol_d = 1'b1;
      end else if (line_done) begin
        x_d       = '0;
        y_d       = y_next;
        err_eol_d = 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
      if (cnt_pop == '0) last_d = 1'b0;
    end
    if (acc) begin
      if (in_stream_tkeep != 4'hF) err_keep_d = 1'b1;
      if (in_stream_tuser) begin
        if (cnt_pop != '0 || x_d != '0 || y_d != '0) err_sof_d = 1'b1;
        x_d    = '0;
        y_d    = '0;
        last_d = in_stream_tlast;
      end else begin
        if (cnt_pop == '0 && x_d == '0 && y_d == '0) err_sof_d = 1'b1;
        if (in_stream_tlast) last_d = 1'b1;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      x_q        <= '0;
      y_q        <= '0;
      last_q     <= 1'b0;
      err_sof_q  <= 1'b0;
      err_eol_q  <= 1'b0;
      err_keep_q <= 1'b0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      last_q     <= last_d;
      err_sof_q  <= err_sof_d;
      err_eol_q  <= err_eol_d;
      err_keep_q <= err_keep_d;
    end
  end

  assign pix_r    = pix.r;
  assign pix_g    = pix.g;
  assign pix_b    = pix.b;
  assign pix_x    = x_q;
  assign pix_y    = y_q;
  assign pix_sof  = (x_q == '0) && (y_q == '0);
  assign pix_eol  = (x_q == X_LAST);
  assign err_sof  = err_sof_q;
  assign err_eol  = err_eol_q;
  assign err_keep = err_keep_q;
endmodule
